// File: rtl/xy_multiplier_pkg.sv
// Shared constants and types for the xy_multiplier_seq coprocessor block:
// mode encodings, the register address map and the control FSM state type.
package xy_multiplier_pkg;

  localparam logic [1:0] MODE_MUL   = 2'b00;
  localparam logic [1:0] MODE_DIFSQ = 2'b01;
  localparam logic [1:0] MODE_SQR   = 2'b10;

  localparam logic [2:0] ADDR_A      = 3'd0;
  localparam logic [2:0] ADDR_B      = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_RESULT = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

endpackage

// File: rtl/xy_mul_core.sv
// One-bit-per-cycle shift-add multiplier datapath.
// Optional macro: XY_MULTIPLIER_SEQ_EARLY_EXIT_EN ends the run once the
// remaining multiplier bits are all zero.
module xy_mul_core
  import xy_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   x_i,
  input  logic [WIDTH-1:0]   y_i,
  output logic [2*WIDTH-1:0] acc_next_o,
  output logic               done_o
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [PW-1:0]    x_q, x_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    acc_step;
  logic [WIDTH-1:0] y_q, y_d;
  logic [CW-1:0]    count_q, count_d;

  // X is kept pre-shifted by count, so X*2^count is just x_q.
  // Load operands on start; otherwise take one shift-add step while running.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    acc_d    = acc_q;
    count_d  = count_q;
    acc_step = y_q[0] ? (acc_q + x_q) : acc_q;
    if (load_i) begin
      x_d     = PW'(x_i);
      y_d     = y_i;
      acc_d   = '0;
      count_d = '0;
    end else if (step_i) begin
      x_d     = x_q << 1;
      y_d     = y_q >> 1;
      acc_d   = acc_step;
      count_d = count_q + 1'b1;
    end
  end

  // Flag the step that completes the product; the top commits acc_next_o then.
  always_comb begin
`ifdef XY_MULTIPLIER_SEQ_EARLY_EXIT_EN
    done_o = step_i && ((y_q >> 1) == '0);
`else
    done_o = step_i && (count_q == CW'(WIDTH - 1));
`endif
    acc_next_o = acc_step;
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/xy_multiplier_seq.sv
// Memory-mapped sequential multiplier: register file, address decode,
// IDLE/RUN control FSM and registered read mux around xy_mul_core.
// Optional macro: XY_MULTIPLIER_SEQ_EARLY_EXIT_EN (data-dependent latency).
module xy_multiplier_seq
  import xy_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               E,
  input  logic               W,
  input  logic               R,
  input  logic [2:0]         ADDR,
  input  logic [WIDTH-1:0]   D,
  output logic [2*WIDTH-1:0] OUT,
  output logic               BUSY,
  output logic               DONE
);

  localparam int unsigned PW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]       mode_q, mode_d;
  logic [PW-1:0]    result_q, result_d;
  logic [PW-1:0]    out_q, out_d;
  logic             done_q, done_d;

  logic             wr_en, rd_en, start;
  logic [WIDTH-1:0] op_x, op_y;
  logic [PW-1:0]    core_acc;
  logic             core_done;

  // Strobe decode and factor selection from the mode in the START write.
  always_comb begin
    wr_en = E && W;
    rd_en = E && R;
    start = wr_en && (state_q == IDLE) && (ADDR == ADDR_CTRL) && D[0];
    case (D[2:1])
      MODE_DIFSQ: begin
        op_x = a_q + b_q;
        op_y = a_q - b_q;
      end
      MODE_SQR: begin
        op_x = a_q;
        op_y = a_q;
      end
      default: begin
        op_x = a_q;
        op_y = b_q;
      end
    endcase
  end

  xy_mul_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk       (CLK),
    .rst       (RST),
    .load_i    (start),
    .step_i    (state_q == RUN),
    .x_i       (op_x),
    .y_i       (op_y),
    .acc_next_o(core_acc),
    .done_o    (core_done)
  );

  // Register writes, read mux, DONE bookkeeping and next state.
  // Completion is applied last so a RESULT read on the completion edge
  // does not clear the freshly set DONE.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    result_d = result_q;
    out_d    = out_q;
    done_d   = done_q;

    if (wr_en && (state_q == IDLE)) begin
      case (ADDR)
        ADDR_A:    a_d    = D;
        ADDR_B:    b_d    = D;
        ADDR_CTRL: mode_d = D[2:1];
        default:   ;
      endcase
    end

    if (start) begin
      done_d  = 1'b0;
      state_d = RUN;
    end

    if (rd_en) begin
      case (ADDR)
        ADDR_A:      out_d = PW'(a_q);
        ADDR_B:      out_d = PW'(b_q);
        ADDR_CTRL:   out_d = PW'(mode_q);
        ADDR_RESULT: out_d = result_q;
        ADDR_STATUS: out_d = PW'({done_q, state_q == RUN});
        default:     out_d = '0;
      endcase
      if (ADDR == ADDR_RESULT) done_d = 1'b0;
    end

    if ((state_q == RUN) && core_done) begin
      result_d = core_acc;
      done_d   = 1'b1;
      state_d  = IDLE;
    end
  end

  // State and register file.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= '0;
      result_q <= '0;
      out_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      out_q    <= out_d;
      done_q   <= done_d;
    end
  end

  assign OUT  = out_q;
  assign BUSY = (state_q == RUN);
  assign DONE = done_q;

endmodule

// File: tb/tb_xy_multiplier_seq.sv
// Scoreboard bench for xy_multiplier_seq: reads push expected OUT values,
// a monitor pops and compares on the edge after each accepted read.
module tb_xy_multiplier_seq;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        E = 1'b0, W = 1'b0, R = 1'b0;
  logic [2:0]  ADDR = '0;
  logic [15:0] D = '0;
  logic [31:0] OUT;
  logic        BUSY, DONE;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned edges = 0;
  int unsigned t0 = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  xy_multiplier_seq #(.WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .E(E), .W(W), .R(R),
    .ADDR(ADDR), .D(D), .OUT(OUT), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  function automatic int unsigned lat(input logic [15:0] y);
    int unsigned l;
`ifdef XY_MULTIPLIER_SEQ_EARLY_EXIT_EN
    l = 1;
    for (int i = 0; i < 16; i++) if (y[i]) l = i + 1;
`else
    l = 16;
`endif
    return l;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
    edges++;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    E = 1'b1; W = 1'b1; ADDR = a; D = d;
    tick();
    E = 1'b0; W = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    E = 1'b1; R = 1'b1; ADDR = a;
    exp_q.push_back(exp);
    name_q.push_back(name);
    tick();
    E = 1'b0; R = 1'b0;
  endtask

  task automatic rw(input logic [2:0] a, input logic [15:0] d, input logic [31:0] exp, input string name);
    E = 1'b1; R = 1'b1; W = 1'b1; ADDR = a; D = d;
    exp_q.push_back(exp);
    name_q.push_back(name);
    tick();
    E = 1'b0; R = 1'b0; W = 1'b0;
  endtask

  task automatic go(input logic [15:0] ctrl);
    wr(3'd2, ctrl);
    t0 = edges;
  endtask

  task automatic wait_done(input int unsigned exp_lat, input string name);
    while (!DONE && (edges - t0) < 200) tick();
    chk(name, edges - t0, exp_lat);
    chk({name, "_busy"}, BUSY, 1'b0);
  endtask

  // Monitor: an accepted read presents its data after that edge.
  initial begin
    logic [31:0] e;
    string       n;
    forever begin
      @(posedge CLK);
      if (E && R && !RST) begin
        @(negedge CLK);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_read: got 0x%0h expected no read", OUT);
        end else begin
          e = exp_q.pop_front();
          n = name_q.pop_front();
          if (OUT !== e) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, OUT, e);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge CLK);
    tick(); tick();
    RST = 1'b0;

    // Reset state
    chk("rst_out", OUT, 32'h0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    rd(3'd0, 32'h0, "rst_a");
    rd(3'd3, 32'h0, "rst_result");
    rd(3'd4, 32'h0, "rst_status");

    // 5,3 difference of squares: 8*2 = 16
    wr(3'd0, 16'd5); wr(3'd1, 16'd3); go(16'h3);
    chk("t1_busy", BUSY, 1'b1);
    chk("t1_done_clr", DONE, 1'b0);
    wait_done(lat(16'd2), "t1_lat");
    rd(3'd4, 32'h2, "t1_status_done");
    rd(3'd3, 32'h10, "t1_result");
    chk("t1_done_after_read", DONE, 1'b0);
    rd(3'd4, 32'h0, "t1_status_clr");
    rd(3'd2, 32'h1, "t1_ctrl");

    // 3,5 difference wraps: 8*0xFFFE; STATUS read on the completion edge
    wr(3'd0, 16'd3); wr(3'd1, 16'd5); go(16'h3);
    repeat (15) tick();
    rd(3'd4, 32'h1, "t2_status_on_completion");
    chk("t2_lat", edges - t0, 32'd16);
    chk("t2_busy", BUSY, 1'b0);
    chk("t2_done", DONE, 1'b1);
    rd(3'd3, 32'h0007FFF0, "t2_result");

    // Max operands, then back-to-back square start
    wr(3'd0, 16'hFFFF); wr(3'd1, 16'hFFFF); go(16'h1);
    wait_done(16, "t3_lat");
    go(16'h5);
    chk("t3_b2b_busy", BUSY, 1'b1);
    chk("t3_b2b_done", DONE, 1'b0);
    wait_done(16, "t3_b2b_lat");
    rd(3'd3, 32'hFFFE0001, "t3_sqr_same");
    wr(3'd1, 16'h0001); go(16'h5);
    wait_done(16, "t3_sqr_lat");
    rd(3'd3, 32'hFFFE0001, "t3_sqr_ignores_b");
    rd(3'd2, 32'h2, "t3_ctrl");

    // Writes and START ignored while busy
    wr(3'd0, 16'd2); wr(3'd1, 16'h8003); go(16'h1);
    tick(); tick();
    wr(3'd0, 16'd7);
    wr(3'd2, 16'h5);
    rd(3'd4, 32'h1, "t4_status_run");
    rd(3'd3, 32'hFFFE0001, "t4_result_prev");
    wait_done(16, "t4_lat");
    rd(3'd0, 32'h2, "t4_a_kept");
    rd(3'd3, 32'h00010006, "t4_result");
    rd(3'd2, 32'h0, "t4_ctrl_kept");

    // Simultaneous read and write returns pre-write value
    rw(3'd0, 16'd9, 32'h2, "rw_old");
    rd(3'd0, 32'h9, "rw_new");

    // Reset in the middle of a run
    wr(3'd1, 16'hFFFF); go(16'h1);
    repeat (7) tick();
    #2 RST = 1'b1;
    #1;
    chk("mid_rst_out", OUT, 32'h0);
    chk("mid_rst_busy", BUSY, 1'b0);
    chk("mid_rst_done", DONE, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    rd(3'd3, 32'h0, "mid_rst_result");
    rd(3'd0, 32'h0, "mid_rst_a");
    wr(3'd0, 16'd6); wr(3'd1, 16'd7); go(16'h1);
    wait_done(lat(16'd7), "post_rst_lat");
    rd(3'd3, 32'd42, "post_rst_result");

    // Small multipliers (short latency with early exit)
    wr(3'd0, 16'd3); wr(3'd1, 16'd2); go(16'h1);
    wait_done(lat(16'd2), "y2_lat");
    rd(3'd3, 32'd6, "y2_result");
    wr(3'd1, 16'd0); go(16'h1);
    wait_done(lat(16'd0), "y0_lat");
    rd(3'd3, 32'd0, "y0_result");

    // Read-only and unused addresses
    wr(3'd3, 16'h1234);
    wr(3'd5, 16'h1234);
    rd(3'd3, 32'd0, "ro_result");
    rd(3'd5, 32'd0, "addr5");
    rd(3'd1, 32'd0, "b_after");

    tick(); tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
